// File: rtl/mem_dma_pkg.sv
// -----------------------------------------------------------------------------
// mem_dma_pkg
//   Shared definitions for the word-copy DMA master on the picorv32 native
//   memory bus: FSM state encodings, write-strobe patterns and the word size.
//   No ports; imported by mem_dma_master.
// -----------------------------------------------------------------------------
package mem_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_GAP_R = 3'd2,
        S_WRITE = 3'd3,
        S_GAP_W = 3'd4
    } state_e;

    localparam logic [3:0]  WSTRB_RD   = 4'h0;
    localparam logic [3:0]  WSTRB_WR   = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_dma_if.sv
// -----------------------------------------------------------------------------
// mem_dma_if
//   picorv32 native memory bus bundle.
//   master modport : drives mem_valid/mem_instr/mem_wstrb/mem_addr/mem_wdata,
//                    receives mem_ready/mem_rdata.
//   slave modport  : the responder side (mirror image).
// -----------------------------------------------------------------------------
interface mem_dma_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_wstrb, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dma_watchdog.sv
// -----------------------------------------------------------------------------
// dma_watchdog
//   Counts cycles a bus request has been waiting for mem_ready.
//   Ports:
//     clk, reset : clock and synchronous active-high reset
//     clr        : clear the count (pulsed on every FSM state change)
//     run        : a request is outstanding and not yet readied this cycle
//     expired    : this is the TIMEOUT-th consecutive waiting cycle
//   Parameter TIMEOUT: number of waiting cycles tolerated (>= 1).
//   Only instantiated when DMA_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module dma_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expired
);

    // The count never needs to exceed TIMEOUT-1: the cycle that would reach
    // TIMEOUT raises expired instead.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_dma_master.sv
// -----------------------------------------------------------------------------
// mem_dma_master
//   Word-copy DMA initiator on the picorv32 native memory bus. Copies
//   len_words 32-bit words from src_addr to dst_addr, one read then one write
//   per word, with a one-cycle idle gap after every bus transfer.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     start               : one-cycle request, honoured only while idle
//     src_addr, dst_addr  : byte addresses, low two bits ignored
//     len_words           : words to copy (0 completes immediately)
//     busy                : copy in progress
//     done                : one-cycle completion/abort pulse
//     error               : sticky abort flag, cleared by an accepted start
//     bus                 : mem_dma_if.master bus port
//   Build option: define DMA_TIMEOUT_EN to enable the mem_ready watchdog
//   (TIMEOUT cycles); otherwise the engine waits forever and error is 0.
// -----------------------------------------------------------------------------
module mem_dma_master
    import mem_dma_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    mem_dma_if.master        bus
);

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [31:0]      data_buf_q, data_buf_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             xfer;
    logic             abort;
    logic             unused_addr_lsbs;

    assign unused_addr_lsbs = ^{src_addr[1:0], dst_addr[1:0]};
    assign xfer             = bus.mem_valid & bus.mem_ready;

`ifdef DMA_TIMEOUT_EN
    logic expired;
    logic error_q, error_d;

    dma_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_d != state_q),
        .run     (bus.mem_valid & ~bus.mem_ready),
        .expired (expired)
    );

    assign abort = expired;

    always_comb begin
        error_d = error_q;
        if (state_q == S_IDLE && start) begin
            error_d = 1'b0;
        end else if (abort) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    // TIMEOUT only has meaning with the watchdog built in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign abort          = 1'b0;
    assign error          = 1'b0;
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        src_ptr_d  = src_ptr_q;
        dst_ptr_d  = dst_ptr_q;
        data_buf_d = data_buf_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_ptr_d = {src_addr[31:2], 2'b00};
                        dst_ptr_d = {dst_addr[31:2], 2'b00};
                        rem_d     = len_words;
                        state_d   = S_READ;
                    end
                end
            end
            S_READ: begin
                if (xfer) begin
                    data_buf_d = bus.mem_rdata;
                    src_ptr_d  = src_ptr_q + WORD_BYTES;
                    state_d    = S_GAP_R;
                end else if (abort) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP_R: state_d = S_WRITE;
            S_WRITE: begin
                if (xfer) begin
                    dst_ptr_d = dst_ptr_q + WORD_BYTES;
                    rem_d     = rem_q - 1'b1;
                    state_d   = S_GAP_W;
                end else if (abort) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GAP_W: begin
                if (rem_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state is reset; pointers, counter and data buffer are always
    // loaded before use, so they are left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        src_ptr_q  <= src_ptr_d;
        dst_ptr_q  <= dst_ptr_d;
        data_buf_q <= data_buf_d;
        rem_q      <= rem_d;
    end

    // Bus outputs decode straight from the state register, so they stay
    // stable for as long as a request waits for mem_ready and read as zero
    // whenever the engine is idle (including during reset).
    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = WSTRB_RD;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            S_READ: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = src_ptr_q;
            end
            S_WRITE: begin
                bus.mem_valid = 1'b1;
                bus.mem_addr  = dst_ptr_q;
                bus.mem_wdata = data_buf_q;
                bus.mem_wstrb = WSTRB_WR;
            end
            default: ;
        endcase
    end

    assign bus.mem_instr = 1'b0;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_mem_dma_master.sv
module tb_mem_dma_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    mem_dma_if bus();

    mem_dma_master #(.LEN_W(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Responder: read data is a fixed pattern of the address; ready comes
    // after 'delay' waiting cycles (0 = same cycle), never when 'hang' is set.
    int delay = 0;
    bit hang  = 1'b0;
    int wcnt  = 0;

    assign bus.mem_ready = bus.mem_valid && !hang && (wcnt == delay);
    assign bus.mem_rdata = 32'hDA7A_0000 | {16'h0000, bus.mem_addr[15:0]};

    always @(posedge clk) begin
        if (bus.mem_valid && !bus.mem_ready) wcnt <= wcnt + 1;
        else                                 wcnt <= 0;
    end

    // Bus monitor.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic [3:0]  log_strb[$];
    int valid_cycles = 0;
    int done_pulses  = 0;
    int b2b          = 0;
    int unstable     = 0;
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic [31:0] p_addr  = '0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    always @(negedge clk) begin
        if (bus.mem_valid) valid_cycles <= valid_cycles + 1;
        if (done)          done_pulses  <= done_pulses + 1;
        if (p_valid && p_ready && bus.mem_valid) b2b <= b2b + 1;
        if (p_valid && !p_ready && bus.mem_valid &&
            (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wdata || bus.mem_wstrb !== p_wstrb))
            unstable <= unstable + 1;
        if (bus.mem_valid && bus.mem_ready) begin
            log_addr.push_back(bus.mem_addr);
            log_strb.push_back(bus.mem_wstrb);
            log_data.push_back(bus.mem_wstrb == 4'hF ? bus.mem_wdata : bus.mem_rdata);
        end
        p_valid <= bus.mem_valid;
        p_ready <= bus.mem_ready;
        p_addr  <= bus.mem_addr;
        p_wdata <= bus.mem_wdata;
        p_wstrb <= bus.mem_wstrb;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start and count negedges until busy rises and until done shows.
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            output int busy_at, output int done_at);
        src_addr  = s;
        dst_addr  = d;
        len_words = n;
        start     = 1'b1;
        busy_at   = -1;
        done_at   = -1;
        for (int k = 1; k <= 400 && done_at < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && busy_at < 0) busy_at = k;
            if (done) done_at = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int busy_at, done_at, base, snap_v, snap_d, snap_u, snap_b;
        bit found;

        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_error", error, 0);
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_wstrb", bus.mem_wstrb, 0);
        chk("rst_addr",  bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_instr", bus.mem_instr, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: zero-wait copy of 3 words 0x100 -> 0x200
        delay = 0;
        base = log_addr.size();
        snap_b = b2b;
        run_copy(32'h100, 32'h200, 16'd3, busy_at, done_at);
        chk("t1_busy_at", busy_at, 1);
        chk("t1_done_at", done_at, 13);
        chk("t1_busy_at_done", busy, 0);
        chk("t1_nxfers", log_addr.size() - base, 6);
        for (int i = 0; i < 3; i++) begin
            chk("t1_rd_addr", log_addr[base + 2*i],     32'h100 + 32'(4*i));
            chk("t1_rd_strb", log_strb[base + 2*i],     4'h0);
            chk("t1_wr_addr", log_addr[base + 2*i + 1], 32'h200 + 32'(4*i));
            chk("t1_wr_strb", log_strb[base + 2*i + 1], 4'hF);
            chk("t1_wr_data", log_data[base + 2*i + 1], 32'hDA7A_0100 + 32'(4*i));
        end
        chk("t1_gap", b2b - snap_b, 0);
        @(negedge clk);
        chk("t1_done_pulse_width", done, 0);

        // 2: zero-length start
        snap_v = valid_cycles;
        len_words = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_busy", busy, 0);
        @(negedge clk);
        chk("t2_done_off", done, 0);
        chk("t2_busy2", busy, 0);
        chk("t2_no_valid", valid_cycles - snap_v, 0);

        // 3: responder with 5 wait cycles, 2 words 0x300 -> 0x380
        delay = 5;
        base = log_addr.size();
        snap_u = unstable;
        run_copy(32'h300, 32'h380, 16'd2, busy_at, done_at);
        chk("t3_done_at", done_at, 29);
        chk("t3_stable", unstable - snap_u, 0);
        chk("t3_nxfers", log_addr.size() - base, 4);
        chk("t3_rd0", log_addr[base],     32'h300);
        chk("t3_wr0", log_addr[base + 1], 32'h380);
        chk("t3_wd0", log_data[base + 1], 32'hDA7A_0300);
        chk("t3_rd1", log_addr[base + 2], 32'h304);
        chk("t3_wr1", log_addr[base + 3], 32'h384);
        chk("t3_wd1", log_data[base + 3], 32'hDA7A_0304);

        // 4: source address wrap, with unaligned low bits ignored
        delay = 0;
        base = log_addr.size();
        run_copy(32'hFFFF_FFFE, 32'h41, 16'd2, busy_at, done_at);
        chk("t4_done_at", done_at, 9);
        chk("t4_rd0", log_addr[base],     32'hFFFF_FFFC);
        chk("t4_wr0", log_addr[base + 1], 32'h40);
        chk("t4_rd1_wrap", log_addr[base + 2], 32'h0000_0000);
        chk("t4_wr1", log_addr[base + 3], 32'h44);
        chk("t4_wd1", log_data[base + 3], 32'hDA7A_0000);

        // 5a: second start mid-copy is ignored
        base = log_addr.size();
        src_addr = 32'h100; dst_addr = 32'h240; len_words = 16'd3;
        start = 1'b1;
        done_at = -1;
        for (int k = 1; k <= 100 && done_at < 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                src_addr = 32'h500; dst_addr = 32'h600; len_words = 16'd1;
                start = 1'b1;
            end
            if (done) done_at = k;
        end
        chk("t5_done_at", done_at, 13);
        chk("t5_nxfers", log_addr.size() - base, 6);
        chk("t5_wr0", log_addr[base + 1], 32'h240);
        chk("t5_rd2", log_addr[base + 4], 32'h108);
        chk("t5_wr2", log_addr[base + 5], 32'h248);
        @(negedge clk);
        chk("t5_idle_after", busy, 0);

        // 5b: reset while a write is waiting
        delay = 3;
        src_addr = 32'h100; dst_addr = 32'h300; len_words = 16'd2;
        start = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 50 && !found; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.mem_valid && bus.mem_wstrb == 4'hF) found = 1'b1;
        end
        chk("t5_reached_write", found, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_valid", bus.mem_valid, 0);
        chk("t5_rst_busy",  busy, 0);
        chk("t5_rst_addr",  bus.mem_addr, 0);
        chk("t5_rst_wdata", bus.mem_wdata, 0);
        chk("t5_rst_wstrb", bus.mem_wstrb, 0);
        chk("t5_rst_done",  done, 0);
        reset = 1'b0;
        snap_d = done_pulses;
        snap_v = valid_cycles;
        repeat (20) @(negedge clk);
        chk("t5_no_done", done_pulses - snap_d, 0);
        chk("t5_no_valid", valid_cycles - snap_v, 0);
        chk("t5_error", error, 0);

`ifdef DMA_TIMEOUT_EN
        // 6: responder never answers, TIMEOUT = 8
        delay = 0;
        hang = 1'b1;
        snap_v = valid_cycles;
        run_copy(32'h100, 32'h200, 16'd1, busy_at, done_at);
        chk("t6_done_at", done_at, 9);
        chk("t6_error", error, 1);
        chk("t6_valid_off", bus.mem_valid, 0);
        chk("t6_valid_cycles", valid_cycles - snap_v, 8);
        hang = 1'b0;
        @(negedge clk);
        chk("t6_error_sticky", error, 1);
        src_addr = 32'h100; dst_addr = 32'h200; len_words = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t6_error_cleared", error, 0);
        done_at = -1;
        for (int k = 2; k <= 50 && done_at < 0; k++) begin
            @(negedge clk);
            if (done) done_at = k;
        end
        chk("t6_recover_done_at", done_at, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
